// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and data-phase record for the AHB masters.
// Widths are sized for the widest supported bus (64-bit, 8 lanes).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam int unsigned MAX_LANE_W = 3;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [1:0]            size;
        logic                  sgn;
        logic [MAX_LANE_W-1:0] lane;
        logic                  local_err;
    } dp_t;

    typedef enum logic {OK, ERR1} state_t;

    // Bytes covered by a transfer of the given size, clamped to the bus width.
    function automatic int unsigned size_bytes(input logic [1:0] size,
                                               input int unsigned max_bytes);
        int unsigned n;
        case ({1'b0, size})
            HSIZE_BYTE:  n = 1;
            HSIZE_HALF:  n = 2;
            HSIZE_WORD:  n = 4;
            HSIZE_DWORD: n = 8;
            default:     n = 8;
        endcase
        return (n > max_bytes) ? max_bytes : n;
    endfunction

endpackage

// File: rtl/ahb_rdata_align.sv
// Read-data lane steering: shift the addressed bytes down, then sign- or
// zero-extend from the top kept bit. Purely combinational.
module ahb_rdata_align
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]     hrdata,
    input  logic [MAX_LANE_W-1:0] lane,
    input  logic [1:0]            size,
    input  logic                  sgn,
    output logic [DATA_W-1:0]     rsp_rdata
);

    logic [DATA_W-1:0] shifted;
    logic              sign_bit;
    int unsigned       nbits;

    always_comb begin
        shifted  = hrdata >> {lane, 3'b000};
        nbits    = 8 * size_bytes(size, DATA_W / 8);
        sign_bit = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) begin
                sign_bit = sgn & shifted[i];
            end
        end
        for (int unsigned i = 0; i < DATA_W; i++) begin
            rsp_rdata[i] = (i < nbits) ? shifted[i] : sign_bit;
        end
    end

endmodule

// File: rtl/ahb_master_pipe.sv
// AHB-Lite single-transfer master with overlapped address/data phases,
// byte-lane steering, local misalignment detection and two-cycle HRESP errors.
module ahb_master_pipe
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = $clog2(DATA_W / 8)
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam int unsigned NBYTES = DATA_W / 8;

    state_t            state_q, state_d;
    dp_t               dp_q, dp_d;
    logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
    logic              misaligned;
    logic              in_err;
    logic              accept;
    logic [DATA_W-1:0] aligned_rdata;

    always_comb begin
        misaligned = 1'b0;
        case ({1'b0, req_size})
            HSIZE_BYTE: misaligned = 1'b0;
            HSIZE_HALF: misaligned = req_addr[0];
            HSIZE_WORD: misaligned = |req_addr[1:0];
            default:    misaligned = (|req_addr[2:0]) || (DATA_W == 32);
        endcase
    end

    assign in_err    = (state_q == ERR1);
    assign req_ready = hready && !in_err;
    assign accept    = req_valid && req_ready;

    // Address phase is driven straight from the request; ERR1 cancels it.
    assign htrans = (req_valid && !misaligned && !in_err && hreset_n) ? HTRANS_NONSEQ
                                                                       : HTRANS_IDLE;
    assign haddr  = req_addr;
    assign hwrite = req_write;
    assign hsize  = {1'b0, req_size};
    assign hburst = HBURST_SINGLE;

    always_comb begin
        dp_d       = dp_q;
        dp_wdata_d = dp_wdata_q;
        if (hready) begin
            dp_d.valid     = accept;
            dp_d.write     = req_write;
            dp_d.size      = req_size;
            dp_d.sgn       = req_signed;
            dp_d.lane      = MAX_LANE_W'(req_addr[LANE_W-1:0]);
            dp_d.local_err = misaligned;
            dp_wdata_d     = req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OK:      if (dp_q.valid && hresp && !hready) state_d = ERR1;
            ERR1:    state_d = OK;
            default: state_d = OK;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q    <= OK;
            dp_q       <= '0;
            dp_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            dp_q       <= dp_d;
            dp_wdata_q <= dp_wdata_d;
        end
    end

    // Replicate the low 2^size bytes of store data across every lane.
    always_comb begin
        int unsigned nb;
        hwdata = '0;
        nb     = size_bytes(dp_q.size, NBYTES);
        if (dp_q.valid && dp_q.write) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                hwdata[b*8 +: 8] = dp_wdata_q[(b & (nb - 1))*8 +: 8];
            end
        end
    end

    ahb_rdata_align #(
        .DATA_W(DATA_W)
    ) u_rdata_align (
        .hrdata    (hrdata),
        .lane      (dp_q.lane),
        .size      (dp_q.size),
        .sgn       (dp_q.sgn),
        .rsp_rdata (aligned_rdata)
    );

    // The ERR1 cycle completes the errored transfer, so it is not masked here.
    assign rsp_valid = dp_q.valid && hready;
    assign rsp_err   = rsp_valid && (dp_q.local_err || hresp);
    assign rsp_rdata = (rsp_valid && !dp_q.write && !rsp_err) ? aligned_rdata : '0;

endmodule

// File: tb/tb_ahb_master_pipe.sv
// Self-checking bench for ahb_master_pipe: vector table, hand sequences for
// wait states / errors / reset, and a randomized run against a reference model.
module tb_ahb_master_pipe;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          hclk = 1'b0;
    logic          hreset_n;
    logic          req_valid, req_ready, req_write, req_signed;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [DW-1:0] hwdata, hrdata;
    logic          hready, hresp;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    ahb_master_pipe #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .hclk       (hclk),
        .hreset_n   (hreset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hburst     (hburst),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [31:0] a,
                           input logic [1:0] s, input logic sg, input logic [31:0] wd);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_size   = s;
        req_signed = sg;
        req_wdata  = wd;
    endtask

    task automatic set_bus(input logic rdy, input logic rsp, input logic [31:0] rd);
        hready = rdy;
        hresp  = rsp;
        hrdata = rd;
    endtask

    // Reference model helpers, written from the bus rules with plain arithmetic.
    function automatic bit is_mis(input logic [31:0] a, input int sz);
        return (sz == 3) || ((a % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [31:0] rep(input logic [31:0] w, input int sz);
        case (sz)
            0:       return (w & 32'hFF) * 32'h0101_0101;
            1:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ld(input logic [31:0] hr, input int lane, input int sz,
                                       input logic sg);
        longint unsigned v, lim;
        int n;
        n   = (sz >= 2) ? 4 : (1 << sz);
        v   = hr;
        v   = v >> (8 * lane);
        lim = 64'd1 << (8 * n);
        v   = v % lim;
        if (sg && n < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
        return v[31:0];
    endfunction

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic        exp_nonseq;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_hwdata;
    } vec_t;

    vec_t vecs[12];

    logic [31:0] burst_data[3];

    // Random-run model state
    logic        m_valid, m_write, m_sgn, m_err;
    logic [1:0]  m_size;
    int          m_lane;
    logic [31:0] m_wdata;
    logic        r_valid, r_write, r_sgn, rdy, need_new;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, rd;

    initial begin
        vecs[0]  = '{0, 32'h103, 2'd0, 1, 0, 32'h80FF_FF00, 1, 0, 32'hFFFF_FF80, 0};
        vecs[1]  = '{0, 32'h103, 2'd0, 0, 0, 32'h80FF_FF00, 1, 0, 32'h0000_0080, 0};
        vecs[2]  = '{0, 32'h102, 2'd1, 1, 0, 32'h80FF_FF00, 1, 0, 32'hFFFF_80FF, 0};
        vecs[3]  = '{0, 32'h100, 2'd1, 0, 0, 32'h80FF_FF00, 1, 0, 32'h0000_FF00, 0};
        vecs[4]  = '{0, 32'h100, 2'd2, 1, 0, 32'h80FF_FF00, 1, 0, 32'h80FF_FF00, 0};
        vecs[5]  = '{0, 32'h101, 2'd0, 1, 0, 32'h80FF_FF00, 1, 0, 32'hFFFF_FFFF, 0};
        vecs[6]  = '{0, 32'h102, 2'd2, 0, 0, 32'h80FF_FF00, 0, 1, 32'h0, 0};
        vecs[7]  = '{1, 32'h102, 2'd1, 0, 32'h0000_1234, 32'h0, 1, 0, 32'h0, 32'h1234_1234};
        vecs[8]  = '{1, 32'h001, 2'd0, 0, 32'hFFFF_FFAB, 32'h0, 1, 0, 32'h0, 32'hABAB_ABAB};
        vecs[9]  = '{1, 32'h200, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 1, 0, 32'h0, 32'hDEAD_BEEF};
        vecs[10] = '{0, 32'h101, 2'd1, 0, 0, 32'h1234_5678, 0, 1, 32'h0, 0};
        vecs[11] = '{0, 32'h000, 2'd3, 0, 0, 32'h1234_5678, 0, 1, 32'h0, 0};
        burst_data[0] = 32'h1111_1111;
        burst_data[1] = 32'h2222_2222;
        burst_data[2] = 32'h3333_3333;

        // Reset state
        hreset_n = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        set_bus(1, 0, 32'hFFFF_FFFF);
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_hburst", hburst, 0);
        hreset_n = 1'b1;
        tick();

        // Zero-wait word load burst
        for (int c = 0; c < 5; c++) begin
            if (c < 3) set_req(1, 0, 32'h100 + 4 * c, 2'd2, 0, 0);
            else       set_req(0, 0, 0, 0, 0, 0);
            set_bus(1, 0, (c >= 1 && c <= 3) ? burst_data[c-1] : 32'h0);
            #1;
            chk("burst_htrans", htrans, (c < 3) ? 2'b10 : 2'b00);
            chk("burst_rsp_valid", rsp_valid, (c >= 1 && c <= 3) ? 1 : 0);
            if (c >= 1 && c <= 3) chk("burst_rdata", rsp_rdata, burst_data[c-1]);
            tick();
        end

        // Vector table: one request then its data phase
        foreach (vecs[i]) begin
            set_req(1, vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata);
            set_bus(1, 0, 32'h0);
            #1;
            chk("vec_htrans", htrans, vecs[i].exp_nonseq ? 2'b10 : 2'b00);
            chk("vec_req_ready", req_ready, 1);
            chk("vec_hsize", hsize, {1'b0, vecs[i].size});
            tick();
            set_req(0, 0, 0, 0, 0, 0);
            set_bus(1, 0, vecs[i].hrdata);
            #1;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_err", rsp_err, vecs[i].exp_err);
            chk("vec_rsp_rdata", rsp_rdata, vecs[i].exp_rdata);
            chk("vec_hwdata", hwdata, vecs[i].exp_hwdata);
            tick();
        end

        // Halfword store with two wait states
        set_req(1, 1, 32'h102, 2'd1, 0, 32'h0000_1234);
        set_bus(1, 0, 0);
        #1;
        chk("st_htrans", htrans, 2'b10);
        chk("st_hwrite", hwrite, 1);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            set_bus((c == 2) ? 1'b1 : 1'b0, 0, 0);
            #1;
            chk("st_hwdata", hwdata, 32'h1234_1234);
            chk("st_rsp_valid", rsp_valid, (c == 2) ? 1 : 0);
            if (c == 2) chk("st_rsp_err", rsp_err, 0);
            tick();
        end
        #1;
        chk("st_rsp_once", rsp_valid, 0);
        tick();

        // Two-cycle bus error with a held pipelined request
        set_req(1, 0, 32'h300, 2'd2, 0, 0);
        set_bus(1, 0, 0);
        #1;
        chk("err_a_htrans", htrans, 2'b10);
        tick();
        set_req(1, 0, 32'h304, 2'd2, 0, 0);
        set_bus(0, 1, 0);
        #1;
        chk("err_c1_rsp_valid", rsp_valid, 0);
        chk("err_c1_req_ready", req_ready, 0);
        tick();
        set_bus(1, 1, 0);
        #1;
        chk("err1_htrans", htrans, 2'b00);
        chk("err1_req_ready", req_ready, 0);
        chk("err1_rsp_valid", rsp_valid, 1);
        chk("err1_rsp_err", rsp_err, 1);
        chk("err1_rsp_rdata", rsp_rdata, 0);
        tick();
        set_bus(1, 0, 32'hA5A5_A5A5);
        #1;
        chk("err_b_htrans", htrans, 2'b10);
        chk("err_b_haddr", haddr, 32'h304);
        chk("err_b_req_ready", req_ready, 1);
        chk("err_b_no_rsp", rsp_valid, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        set_bus(1, 0, 32'h5A5A_5A5A);
        #1;
        chk("err_b_rsp_valid", rsp_valid, 1);
        chk("err_b_rsp_err", rsp_err, 0);
        chk("err_b_rsp_rdata", rsp_rdata, 32'h5A5A_5A5A);
        tick();

        // Reset during a stalled load data phase
        set_req(1, 0, 32'h400, 2'd2, 0, 0);
        set_bus(1, 0, 0);
        tick();
        set_req(1, 0, 32'h500, 2'd2, 0, 0);
        set_bus(0, 0, 32'h1234_5678);
        #1;
        chk("rmid_stall", rsp_valid, 0);
        hreset_n = 1'b0;
        #1;
        set_bus(1, 0, 32'h1234_5678);
        #1;
        chk("rmid_rsp_valid", rsp_valid, 0);
        chk("rmid_htrans", htrans, 2'b00);
        chk("rmid_rsp_rdata", rsp_rdata, 0);
        chk("rmid_rsp_err", rsp_err, 0);
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        hreset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rmid_no_rsp", rsp_valid, 0);
        end

        // Randomized run against the reference model
        m_valid  = 0;
        m_write  = 0;
        m_sgn    = 0;
        m_err    = 0;
        m_size   = 0;
        m_lane   = 0;
        m_wdata  = 0;
        need_new = 1;
        r_valid  = 0;
        r_write  = 0;
        r_sgn    = 0;
        r_size   = 0;
        r_addr   = 0;
        r_wdata  = 0;
        for (int n = 0; n < 400; n++) begin
            if (need_new) begin
                r_valid = ($urandom_range(0, 3) != 0);
                r_write = 1'($urandom_range(0, 1));
                r_size  = 2'($urandom_range(0, 3));
                r_addr  = $urandom;
                if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 1);
                r_sgn   = 1'($urandom_range(0, 1));
                r_wdata = $urandom;
            end
            rdy = ($urandom_range(0, 3) != 0);
            rd  = $urandom;
            set_req(r_valid, r_write, r_addr, r_size, r_sgn, r_wdata);
            set_bus(rdy, 0, rd);
            #1;
            chk("rnd_htrans", htrans, (r_valid && !is_mis(r_addr, r_size)) ? 2'b10 : 2'b00);
            chk("rnd_req_ready", req_ready, rdy);
            chk("rnd_haddr", haddr, r_addr);
            chk("rnd_rsp_valid", rsp_valid, m_valid && rdy);
            chk("rnd_hwdata", hwdata, (m_valid && m_write) ? rep(m_wdata, m_size) : 32'h0);
            if (m_valid && rdy) begin
                chk("rnd_rsp_err", rsp_err, m_err);
                chk("rnd_rsp_rdata", rsp_rdata,
                    (!m_write && !m_err) ? ld(rd, m_lane, m_size, m_sgn) : 32'h0);
            end
            tick();
            if (rdy) begin
                m_valid = r_valid;
                m_write = r_write;
                m_size  = r_size;
                m_sgn   = r_sgn;
                m_lane  = int'(r_addr[1:0]);
                m_wdata = r_wdata;
                m_err   = is_mis(r_addr, r_size);
            end
            need_new = (r_valid && rdy) || !r_valid;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
